// File: rtl/threshold_monitor_pkg.sv
// Shared types and constants for the hysteresis threshold monitor.
// Holds the alarm FSM state encoding and the statistics counter width.
package threshold_monitor_pkg;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        ARMING    = 2'd1,
        ALARM     = 2'd2,
        DISARMING = 2'd3
    } mon_state_t;

    localparam int EVENT_CNT_W = 16;

    // Saturating increment for the alarm-entry counter.
    function automatic logic [EVENT_CNT_W-1:0] sat_inc(input logic [EVENT_CNT_W-1:0] v);
        return (&v) ? v : v + EVENT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/threshold_monitor_if.sv
// Threshold/sample inputs and alarm/statistics outputs of threshold_monitor.
// Signal suffixes are from the monitor's point of view (slave modport).
interface threshold_monitor_if #(
    parameter int DATA_W = 16
);
    import threshold_monitor_pkg::*;

    logic [DATA_W-1:0]      high_threshold_i;
    logic [DATA_W-1:0]      low_threshold_i;
    logic                   sample_valid_i;
    logic [DATA_W-1:0]      sample_i;
    logic                   clear_i;
    logic                   alarm_o;
    logic                   alarm_rise_o;
    logic                   sticky_o;
    logic                   cfg_err_o;
    logic [EVENT_CNT_W-1:0] event_count_o;
    logic [DATA_W-1:0]      peak_o;

    modport master (
        output high_threshold_i, low_threshold_i, sample_valid_i, sample_i, clear_i,
        input  alarm_o, alarm_rise_o, sticky_o, cfg_err_o, event_count_o, peak_o
    );

    modport slave (
        input  high_threshold_i, low_threshold_i, sample_valid_i, sample_i, clear_i,
        output alarm_o, alarm_rise_o, sticky_o, cfg_err_o, event_count_o, peak_o
    );

endinterface

// File: rtl/threshold_monitor_debounce.sv
// Alarm FSM with debounce counter: DEBOUNCE consecutive qualifying samples change state.
// Advances only on v_i; force_normal_i overrides everything. Outputs are registered.
module threshold_monitor_debounce
    import threshold_monitor_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       v_i,
    input  logic       above_i,
    input  logic       below_i,
    input  logic       force_normal_i,
    output mon_state_t state_o,
    output logic       alarm_o,
    output logic       rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             alarm_q, alarm_d;
    logic             rise_q, rise_d;

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_normal_i) begin
            state_d = NORMAL;
            cnt_d   = '0;
        end else if (v_i) begin
            unique case (state_q)
                NORMAL: begin
                    if (above_i) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ALARM;
                        end else begin
                            state_d = ARMING;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ARMING: begin
                    if (!above_i) begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_d = ALARM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ALARM: begin
                    if (below_i) begin
                        if (DEBOUNCE == 1) begin
                            state_d = NORMAL;
                        end else begin
                            state_d = DISARMING;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                DISARMING: begin
                    if (!below_i) begin
                        state_d = ALARM;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // DISARMING -> ALARM is a bounce back, not a new alarm entry, so no rise.
    assign alarm_d = (state_d == ALARM) || (state_d == DISARMING);
    assign rise_d  = (state_d == ALARM) && ((state_q == NORMAL) || (state_q == ARMING));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
        end
    end

    assign state_o = state_q;
    assign alarm_o = alarm_q;
    assign rise_o  = rise_q;

    cnt_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= DEB_LAST);

endmodule

// File: rtl/threshold_monitor.sv
// Hysteresis threshold comparator with debounced alarm, sticky flag and optional
// statistics (event count, peak) enabled by THRESHOLD_MONITOR_STATS_EN. Latency 2 cycles.
module threshold_monitor
    import threshold_monitor_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    threshold_monitor_if.slave   mon
);

    logic       above_q, below_q, v_q;
    logic       cfg_err_q, cfg_err_d;
    logic       sticky_q, sticky_d;
    logic       force_normal;
    logic       alarm, rise;
    mon_state_t state;

    assign cfg_err_d = mon.low_threshold_i > mon.high_threshold_i;
    // Force from the live compare too, so alarm_o drops on the same edge cfg_err_o rises.
    assign force_normal = cfg_err_d | cfg_err_q;
    assign sticky_d     = rise | (sticky_q & ~mon.clear_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            above_q   <= 1'b0;
            below_q   <= 1'b0;
            v_q       <= 1'b0;
            cfg_err_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            v_q       <= mon.sample_valid_i;
            cfg_err_q <= cfg_err_d;
            sticky_q  <= sticky_d;
            if (mon.sample_valid_i) begin
                above_q <= mon.sample_i > mon.high_threshold_i;
                below_q <= mon.sample_i < mon.low_threshold_i;
            end
        end
    end

    threshold_monitor_debounce #(
        .DEBOUNCE       (DEBOUNCE)
    ) u_debounce (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .v_i            (v_q),
        .above_i        (above_q),
        .below_i        (below_q),
        .force_normal_i (force_normal),
        .state_o        (state),
        .alarm_o        (alarm),
        .rise_o         (rise)
    );

    assign mon.alarm_o      = alarm;
    assign mon.alarm_rise_o = rise;
    assign mon.sticky_o     = sticky_q;
    assign mon.cfg_err_o    = cfg_err_q;

`ifdef THRESHOLD_MONITOR_STATS_EN
    logic [EVENT_CNT_W-1:0] event_cnt_q, event_cnt_d;
    logic [DATA_W-1:0]      peak_q, peak_d;

    always_comb begin
        event_cnt_d = event_cnt_q;
        peak_d      = peak_q;
        if (mon.clear_i) begin
            event_cnt_d = rise ? EVENT_CNT_W'(1) : '0;
            peak_d      = mon.sample_valid_i ? mon.sample_i : '0;
        end else begin
            if (rise) begin
                event_cnt_d = sat_inc(event_cnt_q);
            end
            if (mon.sample_valid_i && (mon.sample_i > peak_q)) begin
                peak_d = mon.sample_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            event_cnt_q <= '0;
            peak_q      <= '0;
        end else begin
            event_cnt_q <= event_cnt_d;
            peak_q      <= peak_d;
        end
    end

    assign mon.event_count_o = event_cnt_q;
    assign mon.peak_o        = peak_q;
`else
    assign mon.event_count_o = '0;
    assign mon.peak_o        = '0;
`endif

    alarm_state_a: assert property (@(posedge clk_i) disable iff (rst_i)
        alarm == ((state == ALARM) || (state == DISARMING)));

endmodule
